fp_div_seq: RTL

Iterative IEEE-754 single-precision divider, the inverse companion of the team's combinational floating-point multiplier. It computes a/b with a radix-2 restoring mantissa division, one quotient bit per clock, behind a start/done handshake. It follows the multiplier's arithmetic model: normalized operands only, truncated mantissa, no rounding. It sits beside the multiplier in the floating-point arithmetic library.

---
 rtl/fp_div_pkg.sv | 22 ++
 rtl/fp_div_mant_core.sv | 47 ++++
 rtl/fp_div_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants, FSM state type and helpers for the sequential single-precision divider.
// Imported by the divider top level and by its mantissa datapath.
package fp_div_pkg;

    localparam int unsigned EXP_BIAS   = 127;
    localparam int unsigned MANT_W     = 23;
    localparam int unsigned QUOT_W     = 25;
    localparam int unsigned EXP_W      = 8;
    localparam int unsigned EXP_CALC_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM
    } fsm_state_t;

    // True when the operand has zero magnitude; the sign bit is ignored.
    function automatic logic is_zero_mag(input logic [31:0] x);
        return (x[30:0] == 31'h0);
    endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Radix-2 restoring mantissa divider: 25-bit remainder/quotient pair, one quotient bit per step.
// The quotient is weighted so that q[24] is 2^0, with the bits below it holding the fraction.
module fp_div_mant_core
    import fp_div_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [MANT_W:0]   i_dividend,
    input  logic [MANT_W:0]   i_divisor,
    output logic [QUOT_W-1:0] o_q
);

    logic [QUOT_W-1:0] r_rem;
    logic [MANT_W:0]   r_div;
    logic [QUOT_W-1:0] r_q;

    logic              w_ge;
    logic [QUOT_W-1:0] w_diff;

    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_diff = r_rem - {1'b0, r_div};

    // The remainder always stays below twice the divisor, so the shift never drops a set bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
            r_div <= '0;
            r_q   <= '0;
        end else if (i_load) begin
            r_rem <= {1'b0, i_dividend};
            r_div <= i_divisor;
            r_q   <= '0;
        end else if (i_step) begin
            if (w_ge) begin
                r_rem <= {w_diff[QUOT_W-2:0], 1'b0};
            end else begin
                r_rem <= {r_rem[QUOT_W-2:0], 1'b0};
            end
            r_q <= {r_q[QUOT_W-2:0], w_ge};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider (truncating, normalized operands only).
// Start/done handshake; 26-cycle latency for the normal path, 1 cycle for zero operands.
module fp_div_seq
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam logic [4:0] LAST_COUNT = 5'(QUOT_W - 1);

    fsm_state_t r_state;
    fsm_state_t w_next_state;

    logic [4:0]        r_count;
    logic              r_sign;
    logic [EXP_W-1:0]  r_ea;
    logic [EXP_W-1:0]  r_eb;
    logic              r_special;
    logic [31:0]       r_spec_val;
    logic              r_dbz_pend;
    logic [31:0]       r_result;
    logic              r_busy;
    logic              r_done;
    logic              r_dbz;

    logic              w_accept;
    logic              w_load;
    logic              w_step;
    logic              w_finish;
    logic              w_a_zero;
    logic              w_b_zero;
    logic              w_sign_in;
    logic [QUOT_W-1:0] w_q;
    logic [EXP_CALC_W-1:0] w_exp_calc;
    logic [MANT_W-1:0] w_mant;
    logic [31:0]       w_norm_val;

    assign w_a_zero  = is_zero_mag(a);
    assign w_b_zero  = is_zero_mag(b);
    assign w_sign_in = a[31] ^ b[31];

    fp_div_mant_core u_mant_core (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend ({1'b1, a[MANT_W-1:0]}),
        .i_divisor  ({1'b1, b[MANT_W-1:0]}),
        .o_q        (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_a_zero || w_b_zero) begin
                        w_next_state = NORM;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                w_step = 1'b1;
                if (r_count == LAST_COUNT) begin
                    w_next_state = NORM;
                end
            end
            NORM: begin
                w_finish     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Exponent is computed wide and then truncated; out-of-range values wrap like the multiplier.
    always_comb begin
        w_exp_calc = {2'b00, r_ea} - {2'b00, r_eb}
                   + (w_q[QUOT_W-1] ? EXP_CALC_W'(EXP_BIAS) : EXP_CALC_W'(EXP_BIAS - 1));
        w_mant     = w_q[QUOT_W-1] ? w_q[MANT_W:1] : w_q[MANT_W-1:0];
        w_norm_val = {r_sign, w_exp_calc[EXP_W-1:0], w_mant};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_sign     <= 1'b0;
            r_ea       <= '0;
            r_eb       <= '0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_dbz_pend <= 1'b0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_sign     <= w_sign_in;
                r_ea       <= a[30:23];
                r_eb       <= b[30:23];
                r_special  <= w_a_zero | w_b_zero;
                r_spec_val <= w_b_zero ? {w_sign_in, 8'hFF, 23'h0} : {w_sign_in, 31'h0};
                r_dbz_pend <= w_b_zero;
                r_dbz      <= 1'b0;
                r_busy     <= 1'b1;
                r_count    <= '0;
            end
            if (w_step) begin
                r_count <= r_count + 5'd1;
            end
            if (w_finish) begin
                r_result <= r_special ? r_spec_val : w_norm_val;
                r_dbz    <= r_dbz_pend;
                r_busy   <= 1'b0;
            end
        end
    end

    assign result      = r_result;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule
